// File: rtl/lector_sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lector_sensor_pkg
// Description : Shared types and constants for the lector_sensor front-end:
//               FSM state encoding, frame/sample widths, reset temperature,
//               saturation limits and the "sensor absent" frame pattern.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lector_sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int RAW_W      = 13;
    localparam int TEMP_W     = 11;

    localparam logic signed [TEMP_W-1:0] TEMP_RESET   = 11'sd200;
    localparam int                       TEMP_MIN     = -1024;
    localparam int                       TEMP_MAX     = 1023;
    localparam logic [FRAME_BITS-1:0]    FRAME_ABSENT = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/lector_sensor_conv_temp.sv
`default_nettype none
// ============================================================================
// Module      : conv_temp
// Description : Combinational conversion of a 13-bit two's-complement sensor
//               reading (0.0625 degC/LSB) to signed tenths of a degree:
//               t = floor(raw*5 / 8), saturated to the 11-bit range.
// Ports       : i_raw  - signed raw sensor value [12:0]
//               o_temp - saturated temperature in tenths of degC [10:0]
// Revision    : 1.0 - initial release
// ============================================================================
module conv_temp
    import lector_sensor_pkg::*;
(
    input  logic signed [RAW_W-1:0]  i_raw,
    output logic signed [TEMP_W-1:0] o_temp
);

    localparam logic signed [15:0] c_hi = 16'(TEMP_MAX);
    localparam logic signed [15:0] c_lo = 16'(TEMP_MIN);

    logic signed [15:0] w_prod;
    logic signed [15:0] w_t;

    // raw*5 spans -20480..20475, so 16 bits never overflow
    assign w_prod = $signed({{(16-RAW_W){i_raw[RAW_W-1]}}, i_raw}) * 16'sd5;
    assign w_t    = w_prod >>> 3;

    always_comb begin
        o_temp = w_t[TEMP_W-1:0];
        if (w_t > c_hi) begin
            o_temp = c_hi[TEMP_W-1:0];
        end else if (w_t < c_lo) begin
            o_temp = c_lo[TEMP_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/lector_sensor.sv
`default_nettype none
// ============================================================================
// Module      : lector_sensor
// Description : Periodic SPI mode-0 reader for a digital temperature sensor.
//               Paces frame starts, generates sclk/cs_n, shifts in a 16-bit
//               frame, converts it to tenths of degC and flags an absent
//               sensor (all-ones frame).
// Ports       : clk          - system clock, rising edge
//               arst_n       - asynchronous active-low reset
//               enable       - sampling enable
//               sensor_miso  - serial data from sensor
//               sensor_sclk  - serial clock, idle low
//               sensor_cs_n  - chip select, active low
//               temp_entrada - last good temperature (signed tenths of degC)
//               temp_valid   - one-cycle strobe when temp_entrada updates
//               sensor_fault - last frame was 0xFFFF
// Revision    : 1.0 - initial release
// ============================================================================
module lector_sensor
    import lector_sensor_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     enable,
    input  logic                     sensor_miso,
    output logic                     sensor_sclk,
    output logic                     sensor_cs_n,
    output logic signed [TEMP_W-1:0] temp_entrada,
    output logic                     temp_valid,
    output logic                     sensor_fault
);

    localparam int PACE_W = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PACE_W-1:0] c_pace_last = PACE_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]        c_bit_last  = 4'(FRAME_BITS - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [PACE_W-1:0]         r_pace;
    logic [DIV_W-1:0]          r_div;
    logic [3:0]                r_bit;
    logic                      r_sclk;
    logic                      r_cs_n;
    logic [FRAME_BITS-1:0]     r_shift;
    logic signed [TEMP_W-1:0]  r_temp;
    logic                      r_valid;
    logic                      r_fault;

    logic                      w_start;
    logic                      w_div_end;
    logic                      w_in_shift;
    logic                      w_cs_n_d;
    logic                      w_absent;
    logic signed [TEMP_W-1:0]  w_conv;

    // ------------------------------------------------------------------
    // Pacing: held at 0 while disabled so the first enabled cycle starts
    // a frame; a start while busy is simply lost.
    // ------------------------------------------------------------------
    assign w_start = enable && (r_pace == '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pace <= '0;
        end else if (!enable) begin
            r_pace <= '0;
        end else if (r_pace == '0) begin
            r_pace <= c_pace_last;
        end else begin
            r_pace <= r_pace - 1'b1;
        end
    end

    assign w_div_end  = (r_div == c_div_last);
    assign w_in_shift = (r_state == ST_SHIFT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_SETUP;
            ST_SETUP: if (w_div_end) w_next = ST_SHIFT;
            // leave after the high phase of the last bit
            ST_SHIFT: if (w_div_end && r_sclk && (r_bit == c_bit_last)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from next state so cs_n comes from a flop)
    // ------------------------------------------------------------------
    always_comb begin
        w_cs_n_d = 1'b1;
        if ((w_next == ST_SETUP) || (w_next == ST_SHIFT)) begin
            w_cs_n_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // sclk divider, bit counter, shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if ((r_state == ST_SETUP) || w_in_shift) begin
                r_div <= w_div_end ? '0 : r_div + DIV_W'(1);
            end else begin
                r_div <= '0;
            end

            if (w_in_shift) begin
                if (w_div_end) begin
                    r_sclk <= ~r_sclk;
                    if (!r_sclk) begin
                        // sample on the clk edge where sclk rises
                        r_shift <= {r_shift[FRAME_BITS-2:0], sensor_miso};
                    end else begin
                        r_bit <= r_bit + 4'd1;
                    end
                end
            end else begin
                r_sclk <= 1'b0;
                r_bit  <= '0;
            end
        end
    end

    conv_temp u_conv (
        .i_raw  (r_shift[FRAME_BITS-1:FRAME_BITS-RAW_W]),
        .o_temp (w_conv)
    );

    assign w_absent = (r_shift == FRAME_ABSENT);

    // ------------------------------------------------------------------
    // Registered outputs; result committed on the DONE cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cs_n  <= 1'b1;
            r_temp  <= TEMP_RESET;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_cs_n  <= w_cs_n_d;
            r_valid <= 1'b0;
            if (r_state == ST_DONE) begin
                if (w_absent) begin
                    r_fault <= 1'b1;
                end else begin
                    r_fault <= 1'b0;
                    r_temp  <= w_conv;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign sensor_sclk  = r_sclk;
    assign sensor_cs_n  = r_cs_n;
    assign temp_entrada = r_temp;
    assign temp_valid   = r_valid;
    assign sensor_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_lector_sensor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lector_sensor
// Description : Directed self-checking bench for lector_sensor. A small
//               SPI sensor model serves a programmable 16-bit frame; each
//               frame's temperature, strobe, fault flag and latency are
//               compared to hand-computed values.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lector_sensor;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               enable;
    logic               sensor_miso;
    logic               sensor_sclk;
    logic               sensor_cs_n;
    logic signed [10:0] temp_entrada;
    logic               temp_valid;
    logic               sensor_fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lector_sensor #(
        .CLK_DIV       (4),
        .SAMPLE_PERIOD (1000)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .sensor_miso  (sensor_miso),
        .sensor_sclk  (sensor_sclk),
        .sensor_cs_n  (sensor_cs_n),
        .temp_entrada (temp_entrada),
        .temp_valid   (temp_valid),
        .sensor_fault (sensor_fault)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sensor model: MSB presented while cs_n is low, next bit after each sclk fall
    logic [15:0] tb_frame = 16'h0000;
    logic [3:0]  bit_idx  = 4'd15;

    always @(negedge sensor_sclk or posedge sensor_cs_n) begin
        if (sensor_cs_n) bit_idx = 4'd15;
        else if (bit_idx != 4'd0) bit_idx = bit_idx - 4'd1;
    end
    assign sensor_miso = tb_frame[bit_idx];

    // Cycle-level monitor
    int   cyc = 0;
    logic prev_sclk = 1'b0;
    logic prev_cs   = 1'b1;
    int   rises = 0;
    int   viol  = 0;
    int   falls = 0;
    int   fall_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!arst_n) begin
            rises = 0;
        end else begin
            if ((sensor_sclk !== prev_sclk) && sensor_cs_n && prev_cs) viol++;
            if (sensor_sclk && !prev_sclk) rises++;
            if (prev_cs && !sensor_cs_n) begin
                falls++;
                fall_q.push_back(cyc);
                rises = 0;
            end
            if (!prev_cs && sensor_cs_n) check_val("sclk_rises", rises, 16);
        end
        prev_sclk = sensor_sclk;
        prev_cs   = sensor_cs_n;
    end

    // One frame triggered by a one-cycle enable pulse
    task automatic run_frame(input string tag, input logic [15:0] frame,
                             input int exp_temp, input int exp_vcnt, input int exp_fault);
        int vcnt  = 0;
        int val_c = 0;
        @(negedge clk);
        tb_frame = frame;
        enable   = 1'b1;
        @(negedge clk);
        enable   = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (temp_valid) begin
                vcnt++;
                val_c = cyc;
                if (vcnt == 1) check_val({tag, "_temp_at_valid"}, int'(temp_entrada), exp_temp);
            end
            @(negedge clk);
        end
        check_val({tag, "_valid_pulses"}, vcnt, exp_vcnt);
        check_val({tag, "_temp_held"}, int'(temp_entrada), exp_temp);
        check_val({tag, "_fault"}, int'(sensor_fault), exp_fault);
        if (vcnt == 1) check_val({tag, "_latency"}, val_c - fall_q[$], 133);
    endtask

    initial begin
        int f0;
        int q0;
        int v;

        arst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cs_n",  int'(sensor_cs_n), 1);
        check_val("rst_sclk",  int'(sensor_sclk), 0);
        check_val("rst_temp",  int'(temp_entrada), 200);
        check_val("rst_valid", int'(temp_valid), 0);
        check_val("rst_fault", int'(sensor_fault), 0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Conversion vectors: raw sits in bits[15:3]
        run_frame("raw400",   16'h0C80, 250,   1, 0);
        run_frame("raw288",   16'h0900, 180,   1, 0);
        run_frame("rawm1",    16'hFFF8, -1,    1, 0);
        run_frame("raw4095",  16'h7FF8, 1023,  1, 0);
        run_frame("rawm4096", 16'h8000, -1024, 1, 0);
        run_frame("absent",   16'hFFFF, -1024, 0, 1);
        run_frame("raw320",   16'h0A00, 200,   1, 0);
        run_frame("lowbits",  16'h0C87, 250,   1, 0);

        // Continuous sampling for three periods
        f0 = falls;
        q0 = fall_q.size();
        v  = 0;
        @(negedge clk);
        tb_frame = 16'h0900;
        enable   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (temp_valid) v++;
        end
        enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (temp_valid) v++;
        end
        check_val("period_falls", falls - f0, 3);
        check_val("period_valids", v, 3);
        check_val("period_temp", int'(temp_entrada), 180);
        if (fall_q.size() >= q0 + 3) begin
            check_val("period_gap1", fall_q[q0+1] - fall_q[q0], 1000);
            check_val("period_gap2", fall_q[q0+2] - fall_q[q0+1], 1000);
        end

        // Enable dropped mid-SHIFT: frame completes, nothing further
        f0 = falls;
        v  = 0;
        @(negedge clk);
        tb_frame = 16'h0C80;
        enable   = 1'b1;
        repeat (50) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (temp_valid) v++;
        end
        check_val("drop_falls", falls - f0, 1);
        check_val("drop_valids", v, 1);
        check_val("drop_temp", int'(temp_entrada), 250);

        // Asynchronous reset mid-SHIFT
        @(negedge clk);
        tb_frame = 16'h0A00;
        enable   = 1'b1;
        repeat (50) @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        check_val("arst_cs_n",  int'(sensor_cs_n), 1);
        check_val("arst_sclk",  int'(sensor_sclk), 0);
        check_val("arst_temp",  int'(temp_entrada), 200);
        check_val("arst_valid", int'(temp_valid), 0);
        check_val("arst_fault", int'(sensor_fault), 0);
        repeat (3) @(negedge clk);
        tb_frame = 16'h0C80;
        arst_n   = 1'b1;
        @(negedge clk);
        check_val("restart_cs_n", int'(sensor_cs_n), 0);
        enable = 1'b0;
        v = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (temp_valid) v++;
        end
        check_val("restart_valids", v, 1);
        check_val("restart_temp", int'(temp_entrada), 250);

        check_val("sclk_outside_cs", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lector_sensor.md
# lector_sensor

Serial front-end that periodically reads a digital temperature sensor over an SPI-mode-0 link and produces the signed 11-bit, tenths-of-°C sample consumed by `monitoreo_top` on `temp_entrada`. It owns sample pacing, the serial frame, the unit conversion with saturation, and sensor-absent detection, so the monitor sees one clean, held value plus a one-cycle update strobe.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `sensor_sclk` half-period; ≥ 1.
- `SAMPLE_PERIOD`, 1000: `clk` cycles between frame starts; must be ≥ 34*`CLK_DIV`+2.

- `clk`  in  1  single system clock, rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  sampling enable.
- `sensor_miso`  in  1  serial data from sensor, changes after `sensor_sclk` falls.
- `sensor_sclk`  out  1  serial clock, idle low.
- `sensor_cs_n`  out  1  chip select, active low.
- `temp_entrada`  out  11 signed  last good temperature, tenths of °C; held between updates.
- `temp_valid`  out  1  one-cycle pulse when `temp_entrada` updates.
- `sensor_fault`  out  1  last frame was 0xFFFF (sensor absent); cleared by next good frame.

## Operation
- Reset values: `sensor_cs_n`=1, `sensor_sclk`=0, `temp_entrada`=11'sd200 (20.0 °C, inside the monitor's normal band 180..259), `temp_valid`=0, `sensor_fault`=0, FSM=IDLE, pacing counter=0.
- Pacing counter: while `enable`=1, counts down from `SAMPLE_PERIOD`-1 to 0, reloads on 0 and issues `start`; while `enable`=0 it is held at 0, so the first start occurs in the first cycle `enable` is high.
- FSM states:
  - IDLE: `cs_n`=1, `sclk`=0. On `start` → SETUP.
  - SETUP: `cs_n`=0, `sclk`=0, `CLK_DIV` cycles → SHIFT.
  - SHIFT: 16 bits, MSB first. Each bit is `CLK_DIV` cycles low, then `CLK_DIV` cycles high. `sensor_miso` is shifted in on the clk edge where `sclk` goes 0→1. After the 16th high phase, `sclk`=0 → DONE.
  - DONE: `cs_n`=1 for 1 cycle; update outputs → IDLE.
- Frame format:
  - bits[15:3]: 13-bit two's-complement raw value, 0.0625 °C/LSB.
  - bits[2:0]: ignored.
- Conversion: `prod` = raw*5, 16-bit signed. `t` = `prod` >>> 3 (arithmetic, floor). Saturate `t` to [-1024, 1023].
- Fault:
  - If frame == 16'hFFFF: `sensor_fault`←1, `temp_entrada` unchanged, `temp_valid` stays 0.
  - Otherwise: `sensor_fault`←0, `temp_entrada`←converted value, `temp_valid`=1.
- `start` while not IDLE is dropped; the counter still reloads.
- `enable` falling mid-frame: the current frame completes and updates normally; no further starts.
- `arst_n` asserted mid-frame: the frame is aborted immediately, all outputs take their reset values, and no update is made.

## Timing
- From `sensor_cs_n` falling to `temp_valid`: `CLK_DIV` + 32*`CLK_DIV` + 1 cycles (133 at defaults). `temp_valid` and the new `temp_entrada` appear in the cycle after DONE.
- Frame start to frame start: exactly `SAMPLE_PERIOD` cycles while `enable` stays high.
- `temp_entrada` changes only in a `temp_valid` cycle or on reset.
- All outputs are registered; no combinational path from `sensor_miso` to any output.

## Structure
- Package `lector_sensor_pkg`:
  - state enum {IDLE, SETUP, SHIFT, DONE};
  - `FRAME_BITS`=16, `RAW_W`=13, `TEMP_W`=11;
  - `TEMP_RESET`=11'sd200, `TEMP_MIN`=-1024, `TEMP_MAX`=1023, `FRAME_ABSENT`=16'hFFFF.
- Sub-module `conv_temp`: combinational raw13 → saturated 11-bit tenths. Kept separate for exhaustive unit checking.
- Top contains the pacing counter, sclk divider, bit counter, shift register and FSM.

## Test plan
- Sensor returns raw 400 (frame 16'h0C80) → after 133 cycles, `temp_valid` pulses once; `temp_entrada`=250; `sensor_fault`=0.
- Raw 288 → 180. Raw -1 (frame 16'hFFF8) → -1. Raw 4095 → saturates to 1023. Raw -4096 → saturates to -1024.
- `sensor_miso` stuck high (16'hFFFF) → `sensor_fault`=1, `temp_entrada` holds its previous value, no `temp_valid`. Next frame raw 320 → fault clears, `temp_entrada`=200.
- `enable` high 3*`SAMPLE_PERIOD` → exactly 3 `cs_n` falls, spaced 1000 cycles. `enable` dropped mid-SHIFT → that frame still produces `temp_valid`, then no more frames.
- `arst_n` pulsed low mid-SHIFT → `cs_n`=1, `sclk`=0, `temp_entrada`=200, `temp_valid`=0 immediately (asynchronously). After release with `enable`=1, a fresh frame starts on the first cycle.
- Checked every cycle: `sclk` toggles only while `cs_n`=0, and exactly 16 rising edges occur per frame.
